// File: rtl/psum_accumulator_if.sv
// Handshake bundle for psum_accumulator: term input stream and result output register.
// The slave modport is the accumulator; the master modport is the producer/consumer side.
interface psum_accumulator_if #(
  parameter int W         = 16,
  parameter int CNT_WIDTH = 4
);
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [W-1:0]         data_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [W-1:0]         out_sum_o;
  logic                 out_ovf_o;
  logic [CNT_WIDTH-1:0] term_cnt_o;

  modport slave (
    input  in_valid_i, data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_sum_o, out_ovf_o, term_cnt_o
  );

  modport master (
    output in_valid_i, data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_sum_o, out_ovf_o, term_cnt_o
  );
endinterface

// File: rtl/psum_accumulator.sv
// Windowed signed partial-sum accumulator with sticky overflow and a one-entry output register.
// Define PSUM_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module psum_accumulator #(
  parameter int I_WIDTH   = 8,
  parameter int F_WIDTH   = 8,
  parameter int ACC_LEN   = 9,
  parameter int CNT_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  psum_accumulator_if.slave     bus
);
  localparam int W = I_WIDTH + F_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(ACC_LEN - 1);

  logic signed [W-1:0]  acc_q, acc_d;
  logic [CNT_WIDTH-1:0] term_cnt_q, term_cnt_d;
  logic                 ovf_sticky_q, ovf_sticky_d;
  logic [W-1:0]         out_sum_q, out_sum_d;
  logic                 out_ovf_q, out_ovf_d;
  logic                 out_valid_q, out_valid_d;

  logic                 is_last;
  logic                 in_ready;
  logic                 accept;
  logic signed [W-1:0]  base;
  logic signed [W:0]    next_sum;
  logic                 term_ovf;
  logic                 ovf_window;
  logic signed [W-1:0]  stored;

`ifdef PSUM_ACC_SATURATE_EN
  localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};
`endif

  // Datapath: one W+1 bit signed add; the extra bit exposes signed overflow.
  // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    is_last  = (term_cnt_q == LAST_CNT);
    // The final term stalls only while a finished result is still waiting to be taken.
    in_ready = !(is_last && out_valid_q && !bus.out_ready_i);
    accept   = bus.in_valid_i && in_ready;

    base       = (term_cnt_q == '0) ? '0 : acc_q;
    next_sum   = {base[W-1], base} + {bus.data_i[W-1], bus.data_i};
    term_ovf   = (next_sum[W] != next_sum[W-1]);
    ovf_window = ((term_cnt_q == '0) ? 1'b0 : ovf_sticky_q) | term_ovf;

`ifdef PSUM_ACC_SATURATE_EN
    if (term_ovf) begin
      stored = next_sum[W] ? SAT_MIN : SAT_MAX;
    end else begin
      stored = next_sum[W-1:0];
    end
`else
    stored = next_sum[W-1:0];
`endif
  end

  always_comb begin
    acc_d        = acc_q;
    term_cnt_d   = term_cnt_q;
    ovf_sticky_d = ovf_sticky_q;
    out_sum_d    = out_sum_q;
    out_ovf_d    = out_ovf_q;
    out_valid_d  = out_valid_q;

    if (out_valid_q && bus.out_ready_i) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (is_last) begin
        // A final accept overrides a same-cycle drain, keeping the register full.
        out_sum_d    = stored;
        out_ovf_d    = ovf_window;
        out_valid_d  = 1'b1;
        acc_d        = '0;
        term_cnt_d   = '0;
        ovf_sticky_d = 1'b0;
      end else begin
        acc_d        = stored;
        term_cnt_d   = term_cnt_q + 1'b1;
        ovf_sticky_d = ovf_window;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q        <= '0;
      term_cnt_q   <= '0;
      ovf_sticky_q <= 1'b0;
      out_sum_q    <= '0;
      out_ovf_q    <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      term_cnt_q   <= term_cnt_d;
      ovf_sticky_q <= ovf_sticky_d;
      out_sum_q    <= out_sum_d;
      out_ovf_q    <= out_ovf_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_sum_o   = out_sum_q;
  assign bus.out_ovf_o   = out_ovf_q;
  assign bus.term_cnt_o  = term_cnt_q;
endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Registered partial-sum accumulator that sits directly downstream of the fixed-point `adder` in each processing column. It consumes a stream of signed Q(I_WIDTH).(F_WIDTH) partial sums and accumulates exactly ACC_LEN terms per output window. It flags signed overflow and presents each finished sum on a single-entry output register with a valid/ready handshake. The block provides the cross-cycle state and flow control that the combinational adder lacks.

## Interface
- I_WIDTH, 8: integer bits of the data word, including the sign bit.
- F_WIDTH, 8: fractional bits. The data width is W = I_WIDTH + F_WIDTH.
- ACC_LEN, 9: terms per output window. Must be ≥ 1.
- CNT_WIDTH, 4: counter width. Must satisfy 2^CNT_WIDTH ≥ ACC_LEN.

Ports:
- clk_i, input, 1: the single clock. All state changes on the rising edge.
- rst_i, input, 1: reset, synchronous and active-high.
- in_valid_i, input, 1: data_i holds a valid term.
- in_ready_o, output, 1: the block accepts a term this cycle.
- data_i, input, W: signed input term, typically the adder's sum_o.
- out_valid_o, output, 1: out_sum_o and out_ovf_o hold a finished window.
- out_ready_i, input, 1: the consumer takes the result this cycle.
- out_sum_o, output, W: signed accumulated result.
- out_ovf_o, output, 1: at least one signed overflow occurred in this window.
- term_cnt_o, output, CNT_WIDTH: number of terms accepted in the current window.

## Operation
- Internal state:
  - acc (W bits, signed)
  - term_cnt (CNT_WIDTH bits)
  - ovf_sticky (1 bit)
  - output register: out_sum, out_ovf, out_valid
- Reset (rst_i=1 at an edge):
  - acc=0, term_cnt=0, ovf_sticky=0.
  - out_valid_o=0, out_sum_o=0, out_ovf_o=0.
  - Reset takes priority over every other event. A partially accumulated window is discarded, and a pending output is dropped.
- Input handshake: a term is accepted when in_valid_i && in_ready_o.
- Ready rule: in_ready_o = !(term_cnt==ACC_LEN-1 && out_valid_o && !out_ready_i).
  - Non-final terms are always accepted.
  - The final term is held off only while the output register is occupied and not draining.
- Arithmetic:
  - Compute next = base + data_i at W+1 bits, with both operands sign-extended.
  - base = 0 when term_cnt==0; otherwise base = acc.
  - Overflow: next[W] != next[W-1].
  - Overflow ORs into ovf_sticky. On the first term, ovf_sticky is loaded rather than ORed.
  - Result stored to acc: see Configuration.
- Non-final accept (term_cnt < ACC_LEN-1): acc updates and term_cnt increments.
- Final accept (term_cnt == ACC_LEN-1):
  - The stored result and the final overflow flag load the output register, and out_valid is set to 1.
  - term_cnt, acc and ovf_sticky return to 0.
- Output handshake:
  - out_valid_o && out_ready_i clears out_valid_o at the edge, unless a new final term loads in the same cycle. In that case out_valid_o stays 1 with the new data.
  - out_sum_o and out_ovf_o hold their value while out_valid_o=1 && !out_ready_i.
- ACC_LEN=1: every accepted term is a final term, giving a registered pass-through with overflow flag (overflow is impossible with a 0 base, so out_ovf_o=0).
- No-input cycles (in_valid_i=0) leave acc and term_cnt unchanged. There is no timeout.

## Timing
- Latency: a final term accepted at edge N produces out_valid_o=1 at edge N, visible in cycle N+1.
- Throughput: one term per cycle, and one result per ACC_LEN cycles, with no bubbles when out_ready_i=1.
- in_ready_o depends combinationally on out_ready_i (zero-cycle backpressure). All other outputs are registered.
- Simultaneous output drain and final accept in the same cycle are legal, and neither stalls.
- term_cnt_o is registered and wraps from ACC_LEN-1 to 0, never reaching ACC_LEN.

## Configuration
- PSUM_ACC_SATURATE_EN:
  - Defined: on overflow, the stored result clamps to the most positive value (0x7FFF for W=16) if next is positive, or the most negative value (0x8000) if next is negative. Later terms continue from the clamped value.
  - Undefined: the stored result is next[W-1:0] (two's-complement wrap).
  - out_ovf_o is reported identically in both builds.

## Test plan
All scenarios use W=16 (Q8.8), and ACC_LEN=9 unless stated.
- Basic sum: nine terms of 0x0100 (1.0), out_ready_i=1.
  - Expected: out_sum_o=0x0900 and out_ovf_o=0, one cycle after the 9th accept. in_ready_o stays 1 throughout.
- Signed mix: terms +0x0280, -0x0100, then seven terms of 0x0000.
  - Expected: out_sum_o=0x0180, out_ovf_o=0.
- Overflow: terms 0x7000, 0x2000, then seven terms of 0x0000.
  - With the macro: out_sum_o=0x7FFF.
  - Without the macro: out_sum_o=0x9000.
  - out_ovf_o=1 in both builds.
  - The next window of nine terms of 0x0001 gives 0x0009 with ovf=0 (sticky flag cleared).
- Backpressure: out_ready_i=0 after the first result, then stream the second window.
  - Expected: terms 1–8 accepted, and in_ready_o=0 while the 9th term is presented. The first result holds stable.
  - Raise out_ready_i: the first result drains and the 9th term is accepted in the same cycle. The second result is valid in the next cycle.
- Reset mid-window: after 5 terms, assert rst_i for 1 cycle.
  - Expected: term_cnt_o=0, out_valid_o=0, out_sum_o=0.
  - A fresh nine-term window of 0x0100 then yields 0x0900.
- ACC_LEN=1: terms 0x1234 and 0xFFFF back to back.
  - Expected: out_sum_o=0x1234, then 0xFFFF, on consecutive cycles with ovf=0.
